i4004_bus_master: RTL and testbench

//  4004-style bus initiator: runs 8-phase instruction cycles (A1 A2 A3 M1 M2 X1 X2 X3) on the
//  4-bit multiplexed bus toward our i4001 ROM/IO responder.

---
 rtl/i4004_bus_master.sv | 130 +++++++++++++
 tb/tb_i4004_bus_master.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/i4004_bus_master.sv
// 4004-style bus initiator: sequences PRE/A1..X3 phases on a split 4-bit bus,
// drives address/SYNC/CM_ROM, captures the fetched byte and RDR nibble.
module i4004_bus_master #(
  parameter int CLK_DIV = 4
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        req,
  input  logic [1:0]  op,
  input  logic [11:0] addr,
  input  logic [7:0]  xdata,
  output logic        busy,
  output logic        done,
  output logic [7:0]  rdata,
  output logic [3:0]  io_rdata,
  output logic [3:0]  phase,
  output logic        SYNC,
  output logic        CM_ROM,
  output logic [3:0]  d_out,
  output logic        d_oe,
  input  logic [3:0]  d_in
);

  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

  typedef enum logic [3:0] {
    P_IDLE = 4'd0, P_PRE = 4'd1, P_A1 = 4'd2, P_A2 = 4'd3, P_A3 = 4'd4,
    P_M1 = 4'd5, P_M2 = 4'd6, P_X1 = 4'd7, P_X2 = 4'd8, P_X3 = 4'd9
  } phase_t;

  typedef enum logic [1:0] {OP_FETCH = 2'd0, OP_SRC = 2'd1, OP_WRR = 2'd2, OP_RDR = 2'd3} op_t;

  typedef struct packed {
    op_t         op;
    logic [11:0] addr;
    logic [7:0]  xdata;
  } req_t;

  phase_t        ph, nxt_ph;
  logic [CW-1:0] cnt, nxt_cnt;
  req_t          cur, nxt_req;
  logic          ph_end, accept;
  logic          o_sync, o_cm, o_oe;
  logic [3:0]    o_dout;

  assign phase = ph;

  always_comb begin
    ph_end  = (cnt == LAST);
    accept  = req && ((ph == P_IDLE) || ((ph == P_X3) && ph_end));
    nxt_req = accept ? '{op: op_t'(op), addr: addr, xdata: xdata} : cur;
    nxt_cnt = '0;
    nxt_ph  = ph;
    if (ph == P_IDLE) begin
      if (req) nxt_ph = P_PRE;
    end else if (!ph_end) begin
      nxt_cnt = cnt + CW'(1);
    end else if (ph == P_X3) begin
      // Back-to-back requests skip PRE and restart straight at A1.
      nxt_ph = req ? P_A1 : P_IDLE;
    end else begin
      nxt_ph = phase_t'(ph + 4'd1);
    end
  end

  // Bus outputs are decoded for the phase being entered so they register on the boundary.
  always_comb begin
    o_sync = 1'b0;
    o_cm   = 1'b0;
    o_oe   = 1'b0;
    o_dout = 4'h0;
    case (nxt_ph)
      P_PRE: o_sync = 1'b1;
      P_A1: begin o_oe = 1'b1; o_dout = nxt_req.addr[3:0]; end
      P_A2: begin o_oe = 1'b1; o_dout = nxt_req.addr[7:4]; end
      P_A3: begin o_oe = 1'b1; o_dout = nxt_req.addr[11:8]; o_cm = 1'b1; end
      P_M2: o_cm = (nxt_req.op == OP_WRR) || (nxt_req.op == OP_RDR);
      P_X2: begin
        if (nxt_req.op == OP_SRC) begin
          o_oe = 1'b1; o_dout = nxt_req.xdata[7:4]; o_cm = 1'b1;
        end else if (nxt_req.op == OP_WRR) begin
          o_oe = 1'b1; o_dout = nxt_req.xdata[3:0];
        end
      end
      P_X3: begin
        o_sync = 1'b1;
        if (nxt_req.op == OP_SRC) begin
          o_oe = 1'b1; o_dout = nxt_req.xdata[3:0];
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      ph       <= P_IDLE;
      cnt      <= '0;
      cur      <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      rdata    <= 8'h00;
      io_rdata <= 4'h0;
      SYNC     <= 1'b0;
      CM_ROM   <= 1'b0;
      d_out    <= 4'h0;
      d_oe     <= 1'b0;
    end else begin
      ph     <= nxt_ph;
      cnt    <= nxt_cnt;
      cur    <= nxt_req;
      busy   <= (nxt_ph != P_IDLE);
      done   <= (nxt_ph == P_X3) && (nxt_cnt == LAST);
      SYNC   <= o_sync;
      CM_ROM <= o_cm;
      d_oe   <= o_oe;
      d_out  <= o_dout;
      if (ph_end) begin
        case (ph)
          P_M1: rdata[7:4] <= d_in;
          P_M2: rdata[3:0] <= d_in;
          P_X2: if (cur.op == OP_RDR) io_rdata <= d_in;
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_i4004_bus_master.sv
// Directed bench for i4004_bus_master at CLK_DIV=2 with a simple responder on d_in.
module tb_i4004_bus_master;

  logic        CLK = 1'b0;
  logic        RESET = 1'b1;
  logic        req = 1'b0;
  logic [1:0]  op = 2'd0;
  logic [11:0] addr = 12'h000;
  logic [7:0]  xdata = 8'h00;
  logic        busy, done, SYNC, CM_ROM, d_oe;
  logic [7:0]  rdata;
  logic [3:0]  io_rdata, phase, d_out, d_in;

  logic [3:0] m1 = 4'h0, m2 = 4'h0, iod = 4'h0;
  int n_err = 0, n_chk = 0;

  i4004_bus_master #(.CLK_DIV(2)) dut (
    .CLK(CLK), .RESET(RESET), .req(req), .op(op), .addr(addr), .xdata(xdata),
    .busy(busy), .done(done), .rdata(rdata), .io_rdata(io_rdata), .phase(phase),
    .SYNC(SYNC), .CM_ROM(CM_ROM), .d_out(d_out), .d_oe(d_oe), .d_in(d_in)
  );

  always #5 CLK = ~CLK;

  // Responder: ROM nibbles in M1/M2, port nibble in X2.
  always_comb begin
    d_in = 4'h0;
    if (phase == 4'd5) d_in = m1;
    else if (phase == 4'd6) d_in = m2;
    else if (phase == 4'd8) d_in = iod;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic start(input logic [1:0] o, input logic [11:0] a, input logic [7:0] x);
    @(negedge CLK);
    req = 1'b1; op = o; addr = a; xdata = x;
    @(negedge CLK);
  endtask

  // tab[p] = {SYNC, CM_ROM, d_oe, d_out} for phase index p (0=PRE .. 8=X3).
  task automatic run_phases(input string tag, input logic [8:0][6:0] tab, input int first);
    for (int p = first; p <= 8; p++) begin
      for (int c = 0; c < 2; c++) begin
        chk($sformatf("%s_p%0d_c%0d", tag, p, c),
            {19'd0, phase, busy, done, SYNC, CM_ROM, d_oe, d_out},
            {19'd0, 4'(p + 1), 1'b1, (p == 8 && c == 1), tab[p]});
        @(negedge CLK);
      end
    end
  endtask

  logic [8:0][6:0] tab_f, tab_s, tab_w, tab_f2, tab_r;

  initial begin
    tab_f  = {7'h40, 7'h00, 7'h00, 7'h00, 7'h00, 7'h33, 7'h1A, 7'h15, 7'h40};
    tab_s  = {7'h50, 7'h34, 7'h00, 7'h00, 7'h00, 7'h30, 7'h11, 7'h12, 7'h40};
    tab_w  = {7'h40, 7'h19, 7'h00, 7'h20, 7'h00, 7'h3F, 7'h1F, 7'h1F, 7'h40};
    tab_f2 = {7'h40, 7'h00, 7'h00, 7'h00, 7'h00, 7'h31, 7'h12, 7'h13, 7'h40};
    tab_r  = {7'h40, 7'h00, 7'h00, 7'h20, 7'h00, 7'h34, 7'h15, 7'h16, 7'h00};

    // 1: reset state
    repeat (3) @(negedge CLK);
    chk("rst_ctrl", {phase, SYNC, CM_ROM, d_oe, busy, done}, {4'd0, 5'b0});
    chk("rst_data", {rdata, io_rdata, d_out}, 16'h0000);
    RESET = 1'b0;

    // 2: FETCH 0x3A5
    m1 = 4'hC; m2 = 4'h7; iod = 4'h5;
    start(2'd0, 12'h3A5, 8'h00);
    req = 1'b0;
    run_phases("fetch", tab_f, 0);
    chk("fetch_idle", {phase, busy, done}, 6'd0);
    chk("fetch_rdata", rdata, 8'hC7);
    chk("fetch_io", io_rdata, 4'h0);

    // 3: SRC xdata=0x40
    m1 = 4'h1; m2 = 4'h2; iod = 4'hB;
    start(2'd1, 12'h012, 8'h40);
    req = 1'b0;
    run_phases("src", tab_s, 0);
    chk("src_rdata", rdata, 8'h12);
    chk("src_io", io_rdata, 4'h0);

    // 4: WRR xdata=0x09
    m1 = 4'h6; m2 = 4'h9;
    start(2'd2, 12'hFFF, 8'h09);
    req = 1'b0;
    run_phases("wrr", tab_w, 0);
    chk("wrr_rdata", rdata, 8'h69);
    chk("wrr_io", io_rdata, 4'h0);

    // 5: FETCH then RDR back-to-back; request changes while busy are not sampled
    m1 = 4'hA; m2 = 4'h5; iod = 4'hE;
    start(2'd0, 12'h123, 8'h00);
    op = 2'd3; addr = 12'h456; xdata = 8'hFF;
    run_phases("b2b_fetch", tab_f2, 0);
    req = 1'b0;
    chk("b2b_fetch_rdata", rdata, 8'hA5);
    m1 = 4'h3; m2 = 4'hD;
    run_phases("b2b_rdr", tab_r, 1);
    chk("rdr_idle", {phase, busy, done}, 6'd0);
    chk("rdr_io", io_rdata, 4'hE);
    chk("rdr_rdata", rdata, 8'h3D);

    // 6: reset during M1
    m1 = 4'h8; m2 = 4'h4;
    start(2'd0, 12'h3A5, 8'h00);
    req = 1'b0;
    begin
      int k;
      k = 0;
      while (phase != 4'd5 && k < 40) begin
        @(negedge CLK);
        k++;
      end
      chk("wait_m1", phase, 4'd5);
    end
    RESET = 1'b1;
    @(negedge CLK);
    RESET = 1'b0;
    chk("abort_ctrl", {phase, d_oe, busy, done, SYNC, CM_ROM}, 9'd0);
    chk("abort_data", {rdata, io_rdata}, 12'h000);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("abort_nodone_%0d", i), {phase, done}, 5'd0);
      @(negedge CLK);
    end
    m1 = 4'hC; m2 = 4'h7;
    start(2'd0, 12'h3A5, 8'h00);
    req = 1'b0;
    run_phases("restart", tab_f, 0);
    chk("restart_rdata", rdata, 8'hC7);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule
